uart_cmd_master: RTL and testbench

//  Host-side initiator for the UART FIFO service protocol. Turns user write/read requests into

---
 rtl/uart_service_pkg.sv | 28 ++
 rtl/uart_rsp_watchdog.sv | 39 +++
 rtl/uart_cmd_master.sv | 158 +++++++++++++++
 tb/tb_uart_cmd_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_service_pkg.sv
// Shared definitions for the UART FIFO service protocol: command codes common to
// the host initiator and the service block, plus the initiator FSM encoding.
package uart_service_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h30;
  localparam logic [7:0] CMD_READ  = 8'h31;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_CMD  = 3'd1;
  localparam logic [2:0] ST_WAIT_CMD  = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_WAIT_RSP  = 3'd5;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE,
    StSendCmd  = ST_SEND_CMD,
    StWaitCmd  = ST_WAIT_CMD,
    StSendData = ST_SEND_DATA,
    StWaitData = ST_WAIT_DATA,
    StWaitRsp  = ST_WAIT_RSP
  } cmd_state_e;

  function automatic logic [7:0] cmd_code(input logic is_write);
    return is_write ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/uart_rsp_watchdog.sv
// Response watchdog for uart_cmd_master: counts cycles spent waiting for a read
// response and flags a timeout on the terminal cycle unless the byte arrives then.
module uart_rsp_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic hit,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A response on the terminal cycle takes precedence over the timeout.
  assign timeout = run && !hit && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side command initiator for the UART FIFO service. Optional response
// watchdog enabled by defining UART_CMD_RESPONSE_TIMEOUT_EN.
module uart_cmd_master
  import uart_service_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       tx_start,
  output logic [7:0] tx_symbol,
  input  logic       tx_done,
  input  logic [7:0] rx_symbol,
  input  logic       rx_valid,
  output logic       rx_stray
);

  cmd_state_e state_q, state_d;

  logic       req_write_q, req_write_d;
  logic [7:0] req_data_q, req_data_d;
  logic [7:0] tx_symbol_q, tx_symbol_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rx_stray_q, rx_stray_d;
  logic       rsp_take;
  logic       rsp_timeout;

  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_data_d  = req_data_q;
    tx_symbol_d = tx_symbol_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          req_write_d = req_write;
          req_data_d  = req_data;
          tx_symbol_d = cmd_code(req_write);
          state_d     = StSendCmd;
        end
      end
      StSendCmd: begin
        state_d = StWaitCmd;
      end
      StWaitCmd: begin
        if (tx_done) begin
          if (req_write_q) begin
            tx_symbol_d = req_data_q;
            state_d     = StSendData;
          end else if (rx_valid) begin
            // Fast service: response landed in the same cycle the command finished.
            rsp_take = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWaitRsp;
          end
        end
      end
      StSendData: begin
        state_d = StWaitData;
      end
      StWaitData: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      StWaitRsp: begin
        if (rx_valid) begin
          rsp_take = 1'b1;
          state_d  = StIdle;
        end else if (rsp_timeout) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rsp_take) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rx_symbol;
      rsp_err_d   = 1'b0;
    end
  end

  // Any received byte that is not consumed as a response is dropped and flagged.
  assign rx_stray_d = rx_valid && !rsp_take;

`ifdef UART_CMD_RESPONSE_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  assign wd_clear = (state_d == StWaitRsp) && (state_q != StWaitRsp);
  assign wd_run   = (state_q == StWaitRsp);

  uart_rsp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .run    (wd_run),
    .hit    (rx_valid),
    .timeout(rsp_timeout)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_write_q <= 1'b0;
      req_data_q  <= 8'h00;
      tx_symbol_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      rx_stray_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_data_q  <= req_data_d;
      tx_symbol_q <= tx_symbol_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rx_stray_q  <= rx_stray_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign tx_start  = (state_q == StSendCmd) || (state_q == StSendData);
  assign tx_symbol = tx_symbol_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rx_stray  = rx_stray_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: plays the uart_tx/uart_rx pair and a FIFO service model;
// timeout steps run only when UART_CMD_RESPONSE_TIMEOUT_EN is defined.
module tb_uart_cmd_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       tx_start;
  logic [7:0] tx_symbol;
  logic       tx_done = 1'b0;
  logic [7:0] rx_symbol = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_stray;

  uart_cmd_master #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .tx_start (tx_start),
    .tx_symbol(tx_symbol),
    .tx_done  (tx_done),
    .rx_symbol(rx_symbol),
    .rx_valid (rx_valid),
    .rx_stray (rx_stray)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed traffic, logged mid-cycle.
  logic [7:0] tx_log[$];
  logic [8:0] rsp_log[$];
  int         stray_cnt = 0;

  // Reference: expected traffic and the service FIFO contents.
  logic [7:0] exp_tx[$];
  logic [8:0] exp_rsp[$];
  int         exp_stray = 0;
  logic [7:0] svc_fifo[$];

  always @(negedge clk) begin
    if (tx_start === 1'b1) tx_log.push_back(tx_symbol);
    if (rsp_valid === 1'b1) rsp_log.push_back({rsp_err, rsp_data});
    if (rx_stray === 1'b1) stray_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, fails=%0d", fails);
    $fatal(1, "global timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] svc_read();
    return (svc_fifo.size() > 0) ? svc_fifo.pop_front() : 8'hEE;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_symbol"}, 32'(tx_symbol), 32'h00);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h00);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rx_stray"}, 32'(rx_stray), 32'd0);
  endtask

  task automatic issue(input bit wr, input logic [7:0] data);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_data  = data;
    cycle();
    req_valid = 1'b0;
    req_data  = 8'($urandom);
    chk("cmd_tx_start", 32'(tx_start), 32'd1);
    chk("cmd_symbol", 32'(tx_symbol), wr ? 32'h30 : 32'h31);
    chk("busy_ready", 32'(req_ready), 32'd0);
    exp_tx.push_back(wr ? 8'h30 : 8'h31);
    repeat ($urandom_range(1, 4)) cycle();
  endtask

  // mode 1: read response coincident with command tx_done; mode 2: stray during WAIT_DATA.
  task automatic run_txn(input bit wr, input logic [7:0] data, input int mode);
    logic [7:0] rb;
    issue(wr, data);
    rb = 8'h00;
    if (!wr) rb = svc_read();
    tx_done = 1'b1;
    if (!wr && mode == 1) begin
      rx_valid  = 1'b1;
      rx_symbol = rb;
    end
    cycle();
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    if (wr) begin
      chk("data_tx_start", 32'(tx_start), 32'd1);
      chk("data_symbol", 32'(tx_symbol), 32'(data));
      exp_tx.push_back(data);
      svc_fifo.push_back(data);
      cycle();
      if (mode == 2) begin
        rx_valid  = 1'b1;
        rx_symbol = 8'h55;
        cycle();
        rx_valid = 1'b0;
        chk("stray_wait_data", 32'(rx_stray), 32'd1);
        chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
        exp_stray++;
      end
      repeat ($urandom_range(0, 3)) cycle();
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
      chk("write_ready_back", 32'(req_ready), 32'd1);
      chk("write_no_rsp", 32'(rsp_valid), 32'd0);
    end else begin
      if (mode != 1) begin
        repeat ($urandom_range(0, 4)) cycle();
        chk("read_rsp_early", 32'(rsp_valid), 32'd0);
        rx_valid  = 1'b1;
        rx_symbol = rb;
        cycle();
        rx_valid = 1'b0;
      end
      chk("read_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("read_rsp_data", 32'(rsp_data), 32'(rb));
      chk("read_rsp_err", 32'(rsp_err), 32'd0);
      chk("read_ready_back", 32'(req_ready), 32'd1);
      exp_rsp.push_back({1'b0, rb});
      cycle();
      chk("read_rsp_pulse", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic verify_logs();
    cycle();
    chk("tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
    while (tx_log.size() > 0 && exp_tx.size() > 0)
      chk("tx_byte", 32'(tx_log.pop_front()), 32'(exp_tx.pop_front()));
    tx_log.delete();
    exp_tx.delete();
    chk("rsp_count", 32'(rsp_log.size()), 32'(exp_rsp.size()));
    while (rsp_log.size() > 0 && exp_rsp.size() > 0)
      chk("rsp_entry", 32'(rsp_log.pop_front()), 32'(exp_rsp.pop_front()));
    rsp_log.delete();
    exp_rsp.delete();
    chk("stray_count", 32'(stray_cnt), 32'(exp_stray));
  endtask

  initial begin
    bit         wr;
    logic [7:0] rb;
    int         mode;

    // Power-on reset.
    repeat (3) cycle();
    check_reset_outputs("por");
    rst = 1'b1;
    cycle();

    // Read from an empty service returns 0xEE; then a directed write of 0xA0.
    run_txn(1'b0, 8'h00, 0);
    run_txn(1'b1, 8'hA0, 0);
    verify_logs();

    // Stray byte in IDLE.
    rx_valid  = 1'b1;
    rx_symbol = 8'h55;
    cycle();
    rx_valid = 1'b0;
    chk("stray_idle", 32'(rx_stray), 32'd1);
    chk("stray_idle_no_rsp", 32'(rsp_valid), 32'd0);
    exp_stray++;
    cycle();
    chk("stray_idle_pulse", 32'(rx_stray), 32'd0);

    // Stray during WAIT_DATA, drain FIFO, then a coincident-response read of 0x3C.
    run_txn(1'b1, 8'($urandom), 2);
    run_txn(1'b0, 8'h00, 0);
    run_txn(1'b0, 8'h00, 0);
    run_txn(1'b1, 8'h3C, 0);
    run_txn(1'b0, 8'h00, 1);
    verify_logs();

    // Randomized mix against the service model.
    for (int i = 0; i < 16; i++) begin
      wr   = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 1));
      if (wr && mode == 1) mode = 2;
      run_txn(wr, 8'($urandom), mode);
    end
    verify_logs();

    // Reset in WAIT_CMD abandons the read; the late answer is stray.
    issue(1'b0, 8'h00);
    rst = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    cycle();
    rb        = svc_read();
    rx_valid  = 1'b1;
    rx_symbol = rb;
    cycle();
    rx_valid = 1'b0;
    chk("late_rsp_stray", 32'(rx_stray), 32'd1);
    chk("late_rsp_no_rsp", 32'(rsp_valid), 32'd0);
    exp_stray++;
    run_txn(1'b1, 8'h5A, 0);
    run_txn(1'b0, 8'h00, 0);
    verify_logs();

`ifdef UART_CMD_RESPONSE_TIMEOUT_EN
    // Silent service: timeout fires after 16 cycles in WAIT_RSP.
    issue(1'b0, 8'h00);
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    for (int i = 0; i < 15; i++) chk("timeout_early", 32'(rsp_valid), 32'd0);
    repeat (15) cycle();
    chk("timeout_not_yet", 32'(rsp_valid), 32'd0);
    cycle();
    chk("timeout_valid", 32'(rsp_valid), 32'd1);
    chk("timeout_err", 32'(rsp_err), 32'd1);
    chk("timeout_data", 32'(rsp_data), 32'h00);
    chk("timeout_ready", 32'(req_ready), 32'd1);
    exp_rsp.push_back(9'h100);

    // Response on the terminal cycle wins over the timeout.
    issue(1'b0, 8'h00);
    rb      = svc_read();
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    repeat (15) cycle();
    rx_valid  = 1'b1;
    rx_symbol = rb;
    cycle();
    rx_valid = 1'b0;
    chk("terminal_valid", 32'(rsp_valid), 32'd1);
    chk("terminal_err", 32'(rsp_err), 32'd0);
    chk("terminal_data", 32'(rsp_data), 32'(rb));
    exp_rsp.push_back({1'b0, rb});
    cycle();
    verify_logs();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
